range_sweep_seq: RTL and testbench
==================================

Name: range_sweep_seq

Overview:
- Synthesizable sweep sequencer for stimulus generation, in hardware, on FPGA or in emulation benches.
- Range mode: walks a value from start to stop inclusive, by step.
- Full mode: walks 0..2**width-1.
- Each value is presented on a valid/ready port, with a programmable dwell between values.
- Sits between the bench/CPU config registers and the DUT input under test.

Parameters:
DATA_W, 32, width of swept value and range config
DWELL_W, 16, width of dwell counter
CNT_W, 32, width of issued-value counter

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
start_i  in  1  start pulse; honoured only in IDLE or DONE
abort_i  in  1  stop sweep, return to IDLE
full_mode_i  in  1  1 = full-range sweep, 0 = range sweep
width_i  in  $clog2(DATA_W)+1  bit width for full mode
start_val_i  in  DATA_W  first value, signed (range mode)
stop_val_i  in  DATA_W  last value inclusive, signed (range mode)
step_i  in  DATA_W  increment, signed, must be >0
dwell_i  in  DWELL_W  idle cycles after each accepted value
val_o  out  DATA_W  current value
valid_o  out  1  val_o valid
ready_i  in  1  consumer accepts val_o
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse, sweep completed normally
err_o  out  1  one-cycle pulse, config rejected
count_o  out  CNT_W  values transferred in current/last sweep

Behaviour:
- Reset values (rst_n=0 at posedge): state IDLE; val_o=0, valid_o=0, busy_o=0, done_o=0, err_o=0, count_o=0. Reset mid-sweep aborts immediately; no done_o.
- Config capture: all config inputs are latched on the start_i cycle; later changes are ignored until the next start.
- Full mode: start=0, stop=2**width_i-1, step=1, with unsigned compare.
  - width_i=0 gives the single value 0.
  - width_i>DATA_W is rejected.
- Range mode: signed compare. Rejected if step_i<=0.
- Rejected config: err_o pulses the cycle after start_i; state unchanged; count_o unchanged.
- Empty range (start>stop): state goes straight to DONE; done_o pulses the cycle after start_i; count_o=0; valid_o never asserted.
- States:
  - IDLE: on start_i with valid, non-empty config -> DRIVE. val_o=start, valid_o=1, busy_o=1, count_o=0, all on the next cycle (latency 1).
  - DRIVE: valid_o=1; val_o held stable until valid_o&ready_i. On transfer, count_o+1, then:
    - if last value -> DONE; valid_o=0, done_o=1 next cycle.
    - else if dwell=0 -> stay DRIVE; val_o=next next cycle; valid_o remains 1 (back-to-back, one value per cycle at ready_i=1).
    - else -> DWELL; valid_o=0, counter loaded with dwell.
  - DWELL: counter decrements each cycle. When it reaches 1 -> DRIVE with val_o=next. Exactly dwell cycles of valid_o=0 between transfers.
  - DONE: busy_o=0; val_o holds last value; count_o holds. start_i re-arms the same as in IDLE.
- Last-value test: next = cur+step computed in DATA_W+1 bits, sign-extended (range mode) or zero-extended (full mode). Last when next>stop. This avoids wrap-around, e.g. stop=0x7FFFFFFF, or full mode with width=DATA_W.
- abort_i has priority over all events, including a transfer in the same cycle; that transfer is not counted.
  - Next cycle: IDLE, valid_o=0, busy_o=0, no done_o; count_o holds.
- start_i is ignored in DRIVE and DWELL.
- count_o saturates at 2**CNT_W-1.

Decomposition:
- Shared package seq_pkg:
  - enum seq_state_e {IDLE, DRIVE, DWELL, DONE}
  - struct seq_cfg_t {full_mode, start, stop, step, dwell}
  - constant for width_i width
- One sub-module: dwell_timer (load, decrement, expire flag), DWELL_W wide.

Test Plan:
- Full mode, width_i=3, dwell=0, ready_i=1 -> val_o 0..7 on 8 consecutive cycles starting 1 cycle after start; done_o at cycle 9; count_o=8.
- Range mode, start=-5, stop=5, step=3, dwell=2 -> values -5,-2,1,4 with 2 valid-low cycles between each; count_o=4; 5 is never emitted.
- Backpressure: ready_i toggles 1,0,0,1 -> val_o stable while valid_o&!ready_i; no value skipped or repeated.
- Overflow boundary: start=0x7FFFFFFD, stop=0x7FFFFFFF, step=2 -> 0x7FFFFFFD, 0x7FFFFFFF, then done; no wrap to negative.
- Errors and empty range:
  - step=0 -> err_o pulse, busy_o stays 0.
  - width_i=33 -> err_o.
  - start=4, stop=1 -> done_o pulse, count_o=0, no valid_o.
- Abort and reset: abort_i on a transfer cycle in the 3rd value -> count_o=2, IDLE, no done_o. rst_n=0 mid-DWELL -> all outputs 0 next cycle.

Source files
------------

// File: rtl/range_sweep_seq_pkg.sv
// Shared types and sizing constants for the range sweep sequencer.
// Contents:
//   SeqDataW / SeqDwellW / SeqCntW : default widths of value, dwell and count
//   SeqWidthW                      : width of the full-mode bit-width input
//   seq_state_e                    : sequencer states
//   seq_cfg_t                      : configuration latched on start
package range_sweep_seq_pkg;

  localparam int unsigned SeqDataW  = 32;
  localparam int unsigned SeqDwellW = 16;
  localparam int unsigned SeqCntW   = 32;
  localparam int unsigned SeqWidthW = $clog2(SeqDataW) + 1;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDwell,
    StDone
  } seq_state_e;

  typedef struct packed {
    logic                 full_mode;
    logic [SeqDataW-1:0]  start;
    logic [SeqDataW-1:0]  stop;
    logic [SeqDataW-1:0]  step;
    logic [SeqDwellW-1:0] dwell;
  } seq_cfg_t;

endpackage

// File: rtl/range_sweep_seq_dwell_timer.sv
// Dwell timer: loadable down-counter that flags the last dwell cycle.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   load_i     : load dwell_i into the counter
//   dwell_i    : dwell length in cycles
//   dec_i      : decrement while dwelling
//   expire_o   : counter holds 1, i.e. this is the final dwell cycle
module range_sweep_seq_dwell_timer #(
  parameter int unsigned DWELL_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               dec_i,
  output logic               expire_o
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= dwell_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign expire_o = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/range_sweep_seq.sv
// Sweep sequencer: emits start..stop by step (range mode, signed) or
// 0..2**width-1 (full mode) on a valid/ready port, with a dwell gap
// after each accepted value.
// Ports:
//   clk, rst_n                  : clock, synchronous active-low reset
//   start_i, abort_i            : start pulse (IDLE/DONE only), abort to IDLE
//   full_mode_i, width_i        : full-range select and its bit width
//   start_val_i, stop_val_i     : signed inclusive range (range mode)
//   step_i, dwell_i             : signed increment (>0), idle cycles per value
//   val_o, valid_o, ready_i     : value output handshake
//   busy_o, done_o, err_o       : sweep active, completion pulse, reject pulse
//   count_o                     : saturating count of transferred values
module range_sweep_seq
  import range_sweep_seq_pkg::*;
#(
  parameter int unsigned DATA_W  = SeqDataW,
  parameter int unsigned DWELL_W = SeqDwellW,
  parameter int unsigned CNT_W   = SeqCntW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 full_mode_i,
  input  logic [SeqWidthW-1:0] width_i,
  input  logic [DATA_W-1:0]    start_val_i,
  input  logic [DATA_W-1:0]    stop_val_i,
  input  logic [DATA_W-1:0]    step_i,
  input  logic [DWELL_W-1:0]   dwell_i,
  output logic [DATA_W-1:0]    val_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [CNT_W-1:0]     count_o
);

  localparam logic [SeqWidthW-1:0] WidthMax = SeqWidthW'(DATA_W);

  // One extra bit so start/stop/next compares never wrap; zero-extension in
  // full mode turns the signed compare into an unsigned one.
  function automatic logic [DATA_W:0] ext(input logic [DATA_W-1:0] v, input logic zero_ext);
    return zero_ext ? {1'b0, v} : {v[DATA_W-1], v};
  endfunction

  seq_state_e          state_q;
  seq_cfg_t            cfg_q;
  seq_cfg_t            cfg_new;
  logic [DATA_W-1:0]   val_q;
  logic                valid_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [CNT_W-1:0]    count_q;

  logic [DATA_W-1:0]   full_stop;
  logic [DATA_W:0]     next_ext;
  logic [DATA_W-1:0]   next_val;
  logic                cfg_bad;
  logic                cfg_empty;
  logic                is_last;
  logic                xfer;
  logic                timer_load;
  logic                timer_dec;
  logic                timer_expire;

  always_comb begin
    full_stop = (width_i >= WidthMax) ? '1 : ~({DATA_W{1'b1}} << width_i);

    cfg_new.full_mode = full_mode_i;
    cfg_new.start     = full_mode_i ? '0 : start_val_i;
    cfg_new.stop      = full_mode_i ? full_stop : stop_val_i;
    cfg_new.step      = full_mode_i ? DATA_W'(1) : step_i;
    cfg_new.dwell     = dwell_i;

    cfg_bad   = full_mode_i ? (width_i > WidthMax) : (step_i[DATA_W-1] || (step_i == '0));
    cfg_empty = $signed(ext(cfg_new.start, full_mode_i)) >
                $signed(ext(cfg_new.stop, full_mode_i));

    next_ext = ext(val_q, cfg_q.full_mode) + ext(cfg_q.step, cfg_q.full_mode);
    next_val = next_ext[DATA_W-1:0];
    is_last  = $signed(next_ext) > $signed(ext(cfg_q.stop, cfg_q.full_mode));

    xfer       = (state_q == StDrive) && ready_i && !abort_i;
    timer_load = xfer && !is_last && (cfg_q.dwell != '0);
    timer_dec  = (state_q == StDwell);
  end

  range_sweep_seq_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (timer_load),
    .dwell_i  (cfg_q.dwell),
    .dec_i    (timer_dec),
    .expire_o (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cfg_q   <= '0;
      val_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (abort_i) begin
        // Beats any transfer in the same cycle; that transfer is not counted.
        state_q <= StIdle;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (start_i) begin
              if (cfg_bad) begin
                err_q <= 1'b1;
              end else begin
                cfg_q   <= cfg_new;
                count_q <= '0;
                if (cfg_empty) begin
                  state_q <= StDone;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= StDrive;
                  val_q   <= cfg_new.start;
                  valid_q <= 1'b1;
                  busy_q  <= 1'b1;
                end
              end
            end
          end
          StDrive: begin
            if (ready_i) begin
              if (count_q != '1) count_q <= count_q + CNT_W'(1);
              if (is_last) begin
                state_q <= StDone;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end else if (cfg_q.dwell == '0) begin
                val_q <= next_val;
              end else begin
                state_q <= StDwell;
                valid_q <= 1'b0;
              end
            end
          end
          StDwell: begin
            if (timer_expire) begin
              state_q <= StDrive;
              val_q   <= next_val;
              valid_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign val_o   = val_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign err_o   = err_q;
  assign count_o = count_q;

endmodule

// File: tb/tb_range_sweep_seq.sv
// Bench for range_sweep_seq: directed scenarios with literal expectations
// plus randomized sweeps, all checked every cycle against a 64-bit
// arithmetic model of the sweep.
module tb_range_sweep_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, abort_i, full_mode_i, ready_i;
  logic [5:0]  width_i;
  logic [31:0] start_val_i, stop_val_i, step_i;
  logic [15:0] dwell_i;
  logic [31:0] val_o, count_o;
  logic        valid_o, busy_o, done_o, err_o;

  always #5 clk = ~clk;

  range_sweep_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .full_mode_i (full_mode_i),
    .width_i     (width_i),
    .start_val_i (start_val_i),
    .stop_val_i  (stop_val_i),
    .step_i      (step_i),
    .dwell_i     (dwell_i),
    .val_o       (val_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .count_o     (count_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A sweep is a 64-bit arithmetic walk cur, cur+step, ... while <= stop;
  // m_gap counts remaining idle cycles after an accepted value.
  bit          m_active = 0;
  bit          m_done = 0, m_err = 0;
  longint      m_cur = 0, m_stop = 0, m_step = 0;
  int          m_gap = 0;
  logic [15:0] m_dwell = '0;
  logic [31:0] m_val = '0, m_count = '0;
  longint      ms, me, mst;
  bit          mbad;

  always @(posedge clk) begin
    m_done = 0;
    m_err  = 0;
    if (!rst_n) begin
      m_active = 0; m_gap = 0; m_val = '0; m_count = '0;
    end else if (abort_i) begin
      m_active = 0; m_gap = 0;
    end else if (!m_active) begin
      if (start_i) begin
        if (full_mode_i) begin
          mbad = (width_i > 6'd32);
          ms = 0;
          me = (longint'(1) << width_i) - 1;
          mst = 1;
        end else begin
          ms = longint'($signed(start_val_i));
          me = longint'($signed(stop_val_i));
          mst = longint'($signed(step_i));
          mbad = (mst <= 0);
        end
        if (mbad) m_err = 1;
        else begin
          m_count = '0; m_stop = me; m_step = mst; m_dwell = dwell_i;
          if (ms > me) m_done = 1;
          else begin
            m_active = 1; m_gap = 0; m_cur = ms; m_val = m_cur[31:0];
          end
        end
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) begin
        m_cur += m_step; m_val = m_cur[31:0];
      end
    end else if (ready_i) begin
      if (m_count != '1) m_count++;
      if (m_cur + m_step > m_stop) begin
        m_active = 0; m_done = 1;
      end else if (m_dwell == 0) begin
        m_cur += m_step; m_val = m_cur[31:0];
      end else begin
        m_gap = int'(m_dwell);
      end
    end
  end

  // ---------------- compare process ----------------
  bit chk_en = 0;
  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", 64'(valid_o), 64'(m_active && (m_gap == 0)));
      check("busy",  64'(busy_o),  64'(m_active));
      check("done",  64'(done_o),  64'(m_done));
      check("err",   64'(err_o),   64'(m_err));
      check("count", 64'(count_o), 64'(m_count));
      check("val",   64'(val_o),   64'(m_val));
    end
  end

  // Transfer / completion monitor for the literal checks.
  int          cyc = 0;
  logic [31:0] xq[$];
  int          tq[$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (rst_n && valid_o && ready_i && !abort_i) begin
      xq.push_back(val_o);
      tq.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int start_cyc;

  task automatic go(input bit full, input logic [5:0] w, input logic [31:0] s,
                    input logic [31:0] e, input logic [31:0] st, input logic [15:0] dw);
    full_mode_i = full; width_i = w; start_val_i = s; stop_val_i = e;
    step_i = st; dwell_i = dw;
    xq.delete(); tq.delete();
    start_cyc = cyc;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int maxc);
    int n = 0;
    while (busy_o && n < maxc) begin
      tick();
      n++;
    end
    check(name, 64'(busy_o), 64'd0);
  endtask

  task automatic expect_seq(input string name, input logic [31:0] exp[$]);
    check({name, "_len"}, 64'(xq.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size() && i < xq.size(); i++)
      check(name, 64'(xq[i]), 64'(exp[i]));
  endtask

  task automatic rand_cfg();
    int s;
    full_mode_i = ($urandom_range(0, 9) < 3);
    width_i = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(33, 40)) : 6'($urandom_range(0, 5));
    if ($urandom_range(0, 9) == 0) begin
      start_val_i = 32'h7FFF_FFFF - 32'($urandom_range(0, 12));
      stop_val_i  = 32'h7FFF_FFFF - 32'($urandom_range(0, 3));
    end else begin
      s = int'($urandom_range(0, 40)) - 20;
      start_val_i = 32'(s);
      stop_val_i  = 32'(s + int'($urandom_range(0, 30)) - 5);
    end
    step_i  = 32'($urandom_range(0, 5));
    dwell_i = 16'($urandom_range(0, 3));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start_i = 0; abort_i = 0; full_mode_i = 0; ready_i = 1;
    width_i = '0; start_val_i = '0; stop_val_i = '0; step_i = '0; dwell_i = '0;
    tick();
    chk_en = 1;
    tick();
    check("rst_val",   64'(val_o),   64'd0);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_busy",  64'(busy_o),  64'd0);
    check("rst_count", 64'(count_o), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full mode, width 3, no dwell, always ready.
    ready_i = 1;
    go(1, 6'd3, '0, '0, '0, 16'd0);
    wait_idle("t1_timeout", 50);
    check("t1_done",     64'(done_o),          64'd1);
    check("t1_done_cyc", 64'(cyc - start_cyc), 64'd9);
    check("t1_count",    64'(count_o),         64'd8);
    check("t1_first",    64'(tq.size() > 0 ? tq[0] - start_cyc : -1), 64'd1);
    expect_seq("t1_vals", '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7});
    tick();

    // Range -5..5 step 3, dwell 2.
    go(0, 6'd0, 32'hFFFF_FFFB, 32'd5, 32'd3, 16'd2);
    wait_idle("t2_timeout", 100);
    check("t2_count", 64'(count_o), 64'd4);
    expect_seq("t2_vals", '{32'hFFFF_FFFB, 32'hFFFF_FFFE, 32'd1, 32'd4});
    for (int i = 1; i < tq.size(); i++) check("t2_gap", 64'(tq[i] - tq[i-1]), 64'd3);
    tick();

    // Backpressure with ready pattern 1,0,0,1.
    begin
      int p = 0;
      ready_i = 1;
      go(0, 6'd0, 32'd10, 32'd16, 32'd2, 16'd0);
      while (busy_o && p < 100) begin
        ready_i = (p % 4 == 0) || (p % 4 == 3);
        tick();
        p++;
      end
      check("t3_timeout", 64'(busy_o), 64'd0);
    end
    check("t3_count", 64'(count_o), 64'd4);
    expect_seq("t3_vals", '{32'd10, 32'd12, 32'd14, 32'd16});
    ready_i = 1;
    tick();

    // Signed overflow boundary.
    go(0, 6'd0, 32'h7FFF_FFFD, 32'h7FFF_FFFF, 32'd2, 16'd0);
    wait_idle("t4_timeout", 20);
    check("t4_count", 64'(count_o), 64'd2);
    expect_seq("t4_vals", '{32'h7FFF_FFFD, 32'h7FFF_FFFF});
    tick();

    // Rejected configs and empty range.
    go(0, 6'd0, 32'd0, 32'd5, 32'd0, 16'd0);
    check("t5_step0_err",  64'(err_o),   64'd1);
    check("t5_step0_busy", 64'(busy_o),  64'd0);
    check("t5_step0_cnt",  64'(count_o), 64'd2);
    tick();
    check("t5_err_pulse",  64'(err_o),   64'd0);
    go(1, 6'd33, '0, '0, '0, 16'd0);
    check("t5_w33_err",    64'(err_o),   64'd1);
    tick();
    go(0, 6'd0, 32'd4, 32'd1, 32'd1, 16'd0);
    check("t5_empty_done",  64'(done_o),  64'd1);
    check("t5_empty_cnt",   64'(count_o), 64'd0);
    check("t5_empty_valid", 64'(valid_o), 64'd0);
    tick();

    // Abort on the transfer cycle of the third value.
    go(0, 6'd0, 32'd0, 32'd10, 32'd1, 16'd0);
    tick();
    tick();
    abort_i = 1;
    tick();
    abort_i = 0;
    check("t6_abort_cnt",   64'(count_o), 64'd2);
    check("t6_abort_busy",  64'(busy_o),  64'd0);
    check("t6_abort_done",  64'(done_o),  64'd0);
    check("t6_abort_valid", 64'(valid_o), 64'd0);
    tick();

    // Reset in the middle of a dwell.
    go(0, 6'd0, 32'd3, 32'd10, 32'd1, 16'd5);
    tick();
    tick();
    rst_n = 0;
    tick();
    check("t7_rst_val",   64'(val_o),   64'd0);
    check("t7_rst_busy",  64'(busy_o),  64'd0);
    check("t7_rst_count", 64'(count_o), 64'd0);
    rst_n = 1;
    tick();

    // Randomized sweeps; config inputs and stray starts churn mid-sweep.
    for (int k = 0; k < 40; k++) begin
      int n = 0;
      rand_cfg();
      start_i = 1;
      tick();
      start_i = 0;
      while ((m_active || busy_o) && n < 2000) begin
        rand_cfg();
        ready_i = ($urandom_range(0, 3) != 0);
        abort_i = ($urandom_range(0, 99) < 2);
        start_i = m_active && ($urandom_range(0, 9) == 0);
        tick();
        n++;
      end
      abort_i = 0;
      start_i = 0;
      check("rand_timeout", 64'(busy_o), 64'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
